// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings and constants for the EX stage
package ex_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    localparam logic [7:0] ALU_NOP  = 8'b0000_0000;
    localparam logic [7:0] ALU_AND  = 8'b0010_0100;
    localparam logic [7:0] ALU_OR   = 8'b0010_0101;
    localparam logic [7:0] ALU_XOR  = 8'b0010_0110;
    localparam logic [7:0] ALU_NOR  = 8'b0010_0111;
    localparam logic [7:0] ALU_ADDU = 8'b0010_0001;
    localparam logic [7:0] ALU_SUBU = 8'b0010_0011;
    localparam logic [7:0] ALU_SLT  = 8'b0010_1010;
    localparam logic [7:0] ALU_SLTU = 8'b0010_1011;
    localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative restoring divider, one quotient bit per cycle
module div
    import ex_pkg::*;
#(
    parameter int W = REG_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           signed_div,
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    input  logic           start,
    input  logic           annul,
    output logic [2*W-1:0] result,
    output logic           ready
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    div_state_t     state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2*W:0]   dividend;
    logic [W-1:0]   divisor;
    logic           neg_q, neg_r;

    logic [W-1:0]   abs_op1, abs_op2;
    logic [W+1:0]   diff;
    logic [2*W:0]   step;
    logic [W-1:0]   quot, rem;
    logic           done;

    assign abs_op1 = (signed_div && op1[W-1]) ? -op1 : op1;
    assign abs_op2 = (signed_div && op2[W-1]) ? -op2 : op2;

    // Partial remainder can reach 2*divisor, so the trial subtraction is W+1 bits wide
    assign diff = {1'b0, dividend[2*W:W]} - {2'b00, divisor};
    assign step = diff[W+1] ? {dividend[2*W-1:0], 1'b0}
                            : {diff[W-1:0], dividend[W-1:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= DIV_FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = DIV_FREE;
        end else begin
            case (state)
                DIV_FREE:    if (start) state_next = (op2 == '0) ? DIV_BY_ZERO : DIV_ON;
                DIV_BY_ZERO: state_next = DIV_END;
                DIV_ON:      if (cnt == LAST_STEP) state_next = DIV_END;
                DIV_END:     if (!start) state_next = DIV_FREE;
                default:     state_next = DIV_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (!annul) begin
            case (state)
                DIV_FREE: begin
                    if (start) begin
                        cnt      <= '0;
                        dividend <= {{W{1'b0}}, abs_op1, 1'b0};
                        divisor  <= abs_op2;
                        neg_q    <= signed_div && (op1[W-1] ^ op2[W-1]);
                        neg_r    <= signed_div && op1[W-1];
                    end
                end
                DIV_BY_ZERO: dividend <= '0;
                DIV_ON: begin
                    dividend <= step;
                    cnt      <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quot = neg_q ? -dividend[W-1:0] : dividend[W-1:0];
    assign rem  = neg_r ? -dividend[2*W:W+1] : dividend[2*W:W+1];
    assign done = (state == DIV_END) && !annul && (rst != RstEnable);

    assign ready  = done ? DivResultReady : DivResultNotReady;
    assign result = done ? {rem, quot} : '0;

endmodule

// File: rtl/ex.sv
// rtl/ex.sv - MIPS execute stage; divider present only when EX_DIV_EN is defined
module ex
    import ex_pkg::*;
#(
    parameter int REG_W      = ex_pkg::REG_W,
    parameter int REG_ADDR_W = ex_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  annul_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o
);

    logic [REG_W-1:0]   logic_res, arith_res, wdata;
    logic [2*REG_W-1:0] hilo;
    logic               is_div, whilo, stallreq;
    logic               rst_on;

    assign rst_on = (rst == RstEnable);
    assign is_div = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU);

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            ALU_OR:  logic_res = reg1_i | reg2_i;
            ALU_AND: logic_res = reg1_i & reg2_i;
            ALU_XOR: logic_res = reg1_i ^ reg2_i;
            ALU_NOR: logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            ALU_ADDU: arith_res = reg1_i + reg2_i;
            ALU_SUBU: arith_res = reg1_i - reg2_i;
            ALU_SLT:  arith_res = {{(REG_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            ALU_SLTU: arith_res = {{(REG_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:  arith_res = '0;
        endcase
    end

    always_comb begin
        wdata = '0;
        case (alusel_i)
            SEL_LOGIC: wdata = logic_res;
            SEL_ARITH: wdata = arith_res;
            default:   wdata = '0;
        endcase
    end

`ifdef EX_DIV_EN
    logic               div_ready, div_start;
    logic [2*REG_W-1:0] div_result;

    assign div_start = is_div && !div_ready && !annul_i;

    div #(.W(REG_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .signed_div (aluop_i == ALU_DIV),
        .op1        (reg1_i),
        .op2        (reg2_i),
        .start      (div_start),
        .annul      (annul_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    // A flush must release the pipeline in the same cycle it arrives
    assign stallreq = is_div && !div_ready && !annul_i;
    assign whilo    = is_div && div_ready;
    assign hilo     = div_result;
`else
    logic unused_div_inputs;
    assign unused_div_inputs = &{1'b0, clk, annul_i, is_div};
    assign stallreq = 1'b0;
    assign whilo    = 1'b0;
    assign hilo     = '0;
`endif

    assign wd_o       = rst_on ? '0 : wd_i;
    assign wreg_o     = rst_on ? 1'b0 : wreg_i;
    assign wdata_o    = rst_on ? '0 : wdata;
    assign hi_o       = rst_on ? '0 : hilo[2*REG_W-1:REG_W];
    assign lo_o       = rst_on ? '0 : hilo[REG_W-1:0];
    assign whilo_o    = rst_on ? 1'b0 : whilo;
    assign stallreq_o = rst_on ? 1'b0 : stallreq;

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - self-checking bench for ex: vector table, random ALU ops, divider sequences
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .annul_i    (annul_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [2:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (sel == SEL_LOGIC) begin
            if (op == ALU_OR)  return a | b;
            if (op == ALU_AND) return a & b;
            if (op == ALU_XOR) return a ^ b;
            if (op == ALU_NOR) return ~(a | b);
        end else if (sel == SEL_ARITH) begin
            if (op == ALU_ADDU) return a + b;
            if (op == ALU_SUBU) return a - b;
            if (op == ALU_SLT)  return (sa < sb) ? 32'd1 : 32'd0;
            if (op == ALU_SLTU) return (a < b) ? 32'd1 : 32'd0;
        end
        return 32'd0;
    endfunction

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

`ifdef EX_DIV_EN
    // Expected {hi, lo}: quotient truncates toward zero, remainder follows the dividend
    function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string nm, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_hilo);
        int  stalls;
        bit  done;
        @(posedge clk);
        #1;
        aluop_i  = sgn ? ALU_DIV : ALU_DIVU;
        alusel_i = SEL_NOP;
        reg1_i   = a;
        reg2_i   = b;
        wreg_i   = 1'b0;
        stalls   = 0;
        done     = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (whilo_o) begin
                done = 1'b1;
                chk({nm, "_hilo"}, {hi_o, lo_o}, exp_hilo);
                chk({nm, "_stall_at_end"}, 64'(stallreq_o), 64'd0);
            end else if (stallreq_o) begin
                stalls++;
            end
        end
        chk({nm, "_completed"}, 64'(done), 64'd1);
        chk({nm, "_stall_cycles"}, 64'(stalls), (b == 0) ? 64'd2 : 64'd33);
    endtask

    task automatic drop_to_nop(input string nm);
        @(posedge clk);
        #1;
        aluop_i  = ALU_NOP;
        alusel_i = SEL_NOP;
        @(negedge clk);
        chk({nm, "_whilo_pulse"}, 64'(whilo_o), 64'd0);
    endtask

    task automatic abort_midway(input string nm, input bit use_rst);
        @(posedge clk);
        #1;
        aluop_i = ALU_DIVU;
        alusel_i = SEL_NOP;
        reg1_i = 32'd100;
        reg2_i = 32'd7;
        wd_i = 5'd9;
        wreg_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         annul_i = 1'b1;
        @(negedge clk);
        chk({nm, "_stall"}, 64'(stallreq_o), 64'd0);
        chk({nm, "_whilo"}, 64'(whilo_o), 64'd0);
        if (use_rst)
            chk({nm, "_outs"}, {27'd0, wd_o, wreg_o, wdata_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        annul_i = 1'b0;
        wreg_i = 1'b0;
        aluop_i = ALU_NOP;
        @(negedge clk);
        chk({nm, "_after_whilo"}, 64'(whilo_o), 64'd0);
        chk({nm, "_after_hilo"}, {hi_o, lo_o}, 64'd0);
        run_div({nm, "_fresh"}, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        drop_to_nop({nm, "_fresh"});
    endtask
`endif

    initial begin
        rst = 1'b1;
        annul_i = 1'b0;
        aluop_i = ALU_ADDU;
        alusel_i = SEL_ARITH;
        reg1_i = 32'd1;
        reg2_i = 32'd2;
        wd_i = 5'd3;
        wreg_i = 1'b1;
        @(negedge clk);
        chk("reset_outs", {27'd0, wd_o, wreg_o, wdata_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("reset_flags", {62'd0, whilo_o, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        vecs.push_back('{"addu_wrap", ALU_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 32'd1});
        vecs.push_back('{"slt_neg", ALU_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd1});
        vecs.push_back('{"sltu_big", ALU_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd0});
        vecs.push_back('{"slt_pos", ALU_SLT, SEL_ARITH, 32'd1, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{"slt_min", ALU_SLT, SEL_ARITH, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1});
        vecs.push_back('{"sltu_min", ALU_SLTU, SEL_ARITH, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0});
        vecs.push_back('{"subu_wrap", ALU_SUBU, SEL_ARITH, 32'd0, 32'd1, 32'hFFFF_FFFF});
        vecs.push_back('{"or", ALU_OR, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFFF0_5335});
        vecs.push_back('{"and", ALU_AND, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_4321, 32'h00F0_0220});
        vecs.push_back('{"xor", ALU_XOR, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115});
        vecs.push_back('{"nor", ALU_NOR, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_4321, 32'h000F_ACCA});
        vecs.push_back('{"sel_nop", ALU_ADDU, SEL_NOP, 32'd5, 32'd6, 32'd0});
        vecs.push_back('{"sel_unknown", ALU_ADDU, 3'b111, 32'd5, 32'd6, 32'd0});
        vecs.push_back('{"op_unknown", 8'hFF, SEL_LOGIC, 32'd5, 32'd6, 32'd0});

        foreach (vecs[i]) begin
            aluop_i = vecs[i].op;
            alusel_i = vecs[i].sel;
            reg1_i = vecs[i].a;
            reg2_i = vecs[i].b;
            wd_i = 5'(i + 1);
            wreg_i = i[0];
            #2;
            chk(vecs[i].name, 64'(wdata_o), 64'(vecs[i].exp));
            chk({vecs[i].name, "_pass"}, {58'd0, wd_o, wreg_o}, {58'd0, 5'(i + 1), i[0]});
            chk({vecs[i].name, "_nohilo"}, {62'd0, whilo_o, stallreq_o}, 64'd0);
        end

        for (int i = 0; i < 200; i++) begin
            logic [7:0]  ops [8];
            logic [31:0] exp;
            ops = '{ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_ADDU, ALU_SUBU, ALU_SLT, ALU_SLTU};
            aluop_i = ops[$urandom_range(0, 7)];
            alusel_i = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (aluop_i[3] || aluop_i[1:0] == 2'b01 || aluop_i == ALU_SUBU) ? SEL_ARITH : SEL_LOGIC;
            if (aluop_i == ALU_AND || aluop_i == ALU_OR || aluop_i == ALU_XOR || aluop_i == ALU_NOR)
                if (alusel_i == SEL_ARITH) alusel_i = SEL_LOGIC;
            reg1_i = $urandom;
            reg2_i = ($urandom_range(0, 3) == 0) ? reg1_i : $urandom;
            wd_i = 5'($urandom);
            wreg_i = 1'($urandom);
            exp = alu_model(aluop_i, alusel_i, reg1_i, reg2_i);
            #2;
            chk("rand_alu", {27'd0, wd_o, wreg_o, wdata_o}, {27'd0, wd_i, wreg_i, exp});
        end

`ifdef EX_DIV_EN
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        drop_to_nop("divu_100_7");
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop_to_nop("div_m7_2");
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        drop_to_nop("div_min_m1");
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0);
        drop_to_nop("divu_5_0");
        run_div("divu_bigdiv", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'd1});
        run_div("b2b_second", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100});
        drop_to_nop("b2b_second");

        for (int i = 0; i < 10; i++) begin
            bit          sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 20);
                1: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_div("rand_div", sgn, a, b, div_model(sgn, a, b));
            drop_to_nop("rand_div");
        end

        abort_midway("annul", 1'b0);
        abort_midway("rst", 1'b1);
`else
        @(posedge clk);
        #1;
        aluop_i = ALU_DIVU;
        alusel_i = SEL_NOP;
        reg1_i = 32'd100;
        reg2_i = 32'd7;
        wreg_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("nodiv_flags", {62'd0, whilo_o, stallreq_o}, 64'd0);
            chk("nodiv_hilo", {hi_o, lo_o}, 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
